// File: rtl/branch_target_lut_if.sv
// Lookup / write / invalidate bus of branch_target_lut.
// master drives requests and table updates, slave returns lookup results.
interface branch_target_lut_if #(
    parameter int ADDR_W   = 3,
    parameter int BANK_W   = 2,
    parameter int TARGET_W = 10,
    parameter int CNT_W    = 16
);
    logic                rd_req;
    logic [BANK_W-1:0]   ProgState;
    logic [ADDR_W-1:0]   addr;
    logic                wr_en;
    logic [BANK_W-1:0]   wr_bank;
    logic [ADDR_W-1:0]   wr_addr;
    logic [TARGET_W-1:0] wr_data;
    logic                inv_en;
    logic [BANK_W-1:0]   inv_bank;
    logic                rd_valid;
    logic [TARGET_W-1:0] Target;
    logic                hit;
    logic [CNT_W-1:0]    miss_cnt;

    modport master (
        output rd_req, ProgState, addr, wr_en, wr_bank, wr_addr, wr_data, inv_en, inv_bank,
        input  rd_valid, Target, hit, miss_cnt
    );

    modport slave (
        input  rd_req, ProgState, addr, wr_en, wr_bank, wr_addr, wr_data, inv_en, inv_bank,
        output rd_valid, Target, hit, miss_cnt
    );
endinterface

// File: rtl/branch_target_lut.sv
// Banked branch-target table with per-entry valid bits, 1-cycle pipelined lookup and a saturating miss counter.
// Optional macro LUT_BYPASS_EN forwards a same-cycle write to a matching lookup.
module branch_target_lut #(
    parameter int ADDR_W   = 3,
    parameter int BANK_W   = 2,
    parameter int TARGET_W = 10,
    parameter int CNT_W    = 16
) (
    input logic              Clk,
    input logic              Reset,
    branch_target_lut_if.slave bus
);
    localparam int BANKS   = 1 << BANK_W;
    localparam int ENTRIES = 1 << ADDR_W;
    localparam int DEPTH   = BANKS * ENTRIES;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [BANKS-1:0][ENTRIES-1:0] valid_r;
    logic [BANKS-1:0][ENTRIES-1:0] valid_nxt_s;
    logic [TARGET_W-1:0]           mem_r [DEPTH];

    logic                lk_hit_s;
    logic [TARGET_W-1:0] lk_data_s;
    logic [TARGET_W-1:0] lk_target_s;

    logic                rd_valid_r;
    logic [TARGET_W-1:0] target_r;
    logic                hit_r;
    logic [CNT_W-1:0]    miss_cnt_r;

    // Next valid state: invalidate clears the bank, a write re-validates its own entry on top.
    always_comb begin
        valid_nxt_s = valid_r;
        for (int b = 0; b < BANKS; b++) begin
            for (int e = 0; e < ENTRIES; e++) begin
                valid_nxt_s[b][e] = (valid_r[b][e] & ~(bus.inv_en && (bus.inv_bank == BANK_W'(b))))
                                  | (bus.wr_en && (bus.wr_bank == BANK_W'(b)) && (bus.wr_addr == ADDR_W'(e)));
            end
        end
    end

    // Lookup reads the pre-update table; misses return zero.
    always_comb begin
        lk_hit_s  = valid_r[bus.ProgState][bus.addr];
        lk_data_s = mem_r[{bus.ProgState, bus.addr}];
`ifdef LUT_BYPASS_EN
        if (bus.wr_en && (bus.wr_bank == bus.ProgState) && (bus.wr_addr == bus.addr)) begin
            lk_hit_s  = 1'b1;
            lk_data_s = bus.wr_data;
        end else begin
            lk_hit_s  = valid_r[bus.ProgState][bus.addr];
            lk_data_s = mem_r[{bus.ProgState, bus.addr}];
        end
`endif
        if (lk_hit_s) begin
            lk_target_s = lk_data_s;
        end else begin
            lk_target_s = {TARGET_W{1'b0}};
        end
    end

    // Data array has no reset; only valid bits define table contents.
    always_ff @(posedge Clk) begin
        if (!Reset && bus.wr_en) begin
            mem_r[{bus.wr_bank, bus.wr_addr}] <= bus.wr_data;
        end
    end

    // Valid bits, result registers and miss counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_r    <= '0;
            rd_valid_r <= 1'b0;
            target_r   <= {TARGET_W{1'b0}};
            hit_r      <= 1'b0;
            miss_cnt_r <= {CNT_W{1'b0}};
        end else begin
            valid_r    <= valid_nxt_s;
            rd_valid_r <= bus.rd_req;
            if (bus.rd_req) begin
                target_r <= lk_target_s;
                hit_r    <= lk_hit_s;
                if (!lk_hit_s && (miss_cnt_r != CNT_MAX)) begin
                    miss_cnt_r <= miss_cnt_r + CNT_W'(1);
                end
            end
        end
    end

    assign bus.rd_valid = rd_valid_r;
    assign bus.Target   = target_r;
    assign bus.hit      = hit_r;
    assign bus.miss_cnt = miss_cnt_r;
endmodule

// File: tb/tb_branch_target_lut.sv
// Directed bench for branch_target_lut: a default instance and a CNT_W=2 instance share one stimulus stream.
module tb_branch_target_lut;
    logic       Clk = 1'b0;
    logic       Reset;
    logic       rd_req;
    logic [1:0] ps;
    logic [2:0] addr;
    logic       wr_en;
    logic [1:0] wr_bank;
    logic [2:0] wr_addr;
    logic [9:0] wr_data;
    logic       inv_en;
    logic [1:0] inv_bank;

    int n_vec = 0;
    int n_err = 0;
    int exp_miss = 0;

    branch_target_lut_if #(.CNT_W(16)) bus_a ();
    branch_target_lut_if #(.CNT_W(2))  bus_b ();

    assign bus_a.rd_req = rd_req;   assign bus_b.rd_req = rd_req;
    assign bus_a.ProgState = ps;    assign bus_b.ProgState = ps;
    assign bus_a.addr = addr;       assign bus_b.addr = addr;
    assign bus_a.wr_en = wr_en;     assign bus_b.wr_en = wr_en;
    assign bus_a.wr_bank = wr_bank; assign bus_b.wr_bank = wr_bank;
    assign bus_a.wr_addr = wr_addr; assign bus_b.wr_addr = wr_addr;
    assign bus_a.wr_data = wr_data; assign bus_b.wr_data = wr_data;
    assign bus_a.inv_en = inv_en;   assign bus_b.inv_en = inv_en;
    assign bus_a.inv_bank = inv_bank; assign bus_b.inv_bank = inv_bank;

    branch_target_lut #(.CNT_W(16)) u_dut_a (.Clk(Clk), .Reset(Reset), .bus(bus_a));
    branch_target_lut #(.CNT_W(2))  u_dut_b (.Clk(Clk), .Reset(Reset), .bus(bus_b));

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_in();
        rd_req = 1'b0; wr_en = 1'b0; inv_en = 1'b0;
    endtask

    task automatic set_rd(input logic [1:0] b, input logic [2:0] a);
        rd_req = 1'b1; ps = b; addr = a;
    endtask

    task automatic set_wr(input logic [1:0] b, input logic [2:0] a, input logic [9:0] d);
        wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    endtask

    task automatic check_res(input string tag, input logic v, input logic h, input logic [9:0] t);
        check_val({tag, ".rd_valid"}, 32'(bus_a.rd_valid), 32'(v));
        check_val({tag, ".hit"},      32'(bus_a.hit),      32'(h));
        check_val({tag, ".Target"},   32'(bus_a.Target),   32'(t));
        check_val({tag, ".miss_cnt"}, 32'(bus_a.miss_cnt), 32'(exp_miss));
        check_val({tag, ".miss_sat"}, 32'(bus_b.miss_cnt), 32'((exp_miss > 3) ? 3 : exp_miss));
    endtask

    initial begin
        ps = 2'd0; addr = 3'd0; wr_bank = 2'd0; wr_addr = 3'd0; wr_data = 10'd0; inv_bank = 2'd0;
        clear_in();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        check_res("reset", 1'b0, 1'b0, 10'h000);

        // empty-table lookup misses
        set_rd(2'd0, 3'd0);
        tick();
        clear_in();
        exp_miss = 1;
        check_res("empty_miss", 1'b1, 1'b0, 10'h000);

        set_wr(2'd1, 3'd5, 10'h2A5);
        tick();
        clear_in();
        check_val("no_result_on_write.rd_valid", 32'(bus_a.rd_valid), 32'(0));
        set_rd(2'd1, 3'd5);
        tick();
        clear_in();
        check_res("hit_1_5", 1'b1, 1'b1, 10'h2A5);
        tick();
        check_res("hold_idle", 1'b0, 1'b1, 10'h2A5);

        // fill bank 2 then back-to-back lookups
        for (int i = 0; i < 8; i++) begin
            set_wr(2'd2, 3'(i), 10'(i));
            tick();
        end
        clear_in();
        for (int i = 0; i < 8; i++) begin
            set_rd(2'd2, 3'(i));
            tick();
            check_res($sformatf("b2b_%0d", i), 1'b1, 1'b1, 10'(i));
        end
        clear_in();
        tick();
        check_val("b2b_end.rd_valid", 32'(bus_a.rd_valid), 32'(0));

        // same-cycle write and lookup of an empty entry
        set_wr(2'd3, 3'd2, 10'h155);
        set_rd(2'd3, 3'd2);
        tick();
        clear_in();
`ifdef LUT_BYPASS_EN
        check_res("wr_rd_same", 1'b1, 1'b1, 10'h155);
`else
        exp_miss = exp_miss + 1;
        check_res("wr_rd_same", 1'b1, 1'b0, 10'h000);
`endif
        set_rd(2'd3, 3'd2);
        tick();
        clear_in();
        check_res("after_wr_rd", 1'b1, 1'b1, 10'h155);

        // invalidate bank 1 with write to [1][0]; lookup in same cycle sees old state
        inv_en = 1'b1; inv_bank = 2'd1;
        set_wr(2'd1, 3'd0, 10'd7);
        set_rd(2'd1, 3'd5);
        tick();
        clear_in();
        check_res("inv_pre_state", 1'b1, 1'b1, 10'h2A5);
        set_rd(2'd1, 3'd0);
        tick();
        check_res("inv_wr_keep", 1'b1, 1'b1, 10'd7);
        set_rd(2'd1, 3'd5);
        tick();
        exp_miss = exp_miss + 1;
        check_res("inv_cleared", 1'b1, 1'b0, 10'h000);
        set_rd(2'd2, 3'd7);
        tick();
        clear_in();
        check_res("other_bank_ok", 1'b1, 1'b1, 10'd7);

        // five misses: narrow counter saturates at 3
        for (int i = 1; i <= 5; i++) begin
            set_rd(2'd0, 3'(i));
            tick();
            exp_miss = exp_miss + 1;
            check_res($sformatf("miss_run_%0d", i), 1'b1, 1'b0, 10'h000);
        end
        clear_in();

        // lookup right before reset; requests during reset ignored
        set_rd(2'd2, 3'd3);
        tick();
        check_res("pre_reset_rd", 1'b1, 1'b1, 10'd3);
        Reset = 1'b1;
        set_rd(2'd2, 3'd4);
        set_wr(2'd0, 3'd0, 10'h011);
        tick();
        Reset = 1'b0;
        clear_in();
        exp_miss = 0;
        check_res("post_reset", 1'b0, 1'b0, 10'h000);
        tick();
        check_res("reset_req_ignored", 1'b0, 1'b0, 10'h000);
        set_rd(2'd2, 3'd3);
        tick();
        exp_miss = 1;
        check_res("reset_miss_2_3", 1'b1, 1'b0, 10'h000);
        set_rd(2'd0, 3'd0);
        tick();
        exp_miss = 2;
        check_res("reset_wr_ignored", 1'b1, 1'b0, 10'h000);
        set_rd(2'd1, 3'd0);
        tick();
        clear_in();
        exp_miss = 3;
        check_res("reset_miss_1_0", 1'b1, 1'b0, 10'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
